sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Two-requester arbiter and sequencer for one single-port SRAM macro: CSN/WEN active-low, 4-bit byte enable, negedge write, asynchronous read.
- Shares the SRAM between port 0 (instruction fetch) and port 1 (load/store unit).
- Per-port valid/ready request handshake and one-cycle response pulse.
- Drives all SRAM control and data-in pins and registers read data back to the owning port.

Parameters:
- AWIDTH, 12, word-address width; matches the SRAM ADDR width.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- req0_valid  input  1  port 0 request present.
- req0_ready  output  1  port 0 request accepted this cycle.
- req0_we  input  1  1 = write, 0 = read.
- req0_be  input  4  byte enables; used for writes only.
- req0_addr  input  AWIDTH  word address.
- req0_wdata  input  32  write data.
- rsp0_valid  output  1  one-cycle completion pulse for port 0.
- rsp0_rdata  output  32  read data for port 0.
- req1_valid, req1_ready, req1_we, req1_be, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- sram_csn  output  1  SRAM chip select, active-low.
- sram_wen  output  1  SRAM write enable, active-low.
- sram_addr  output  AWIDTH  SRAM address.
- sram_be  output  4  SRAM byte enable.
- sram_di  output  32  SRAM write data.
- sram_dout  input  32  SRAM read data; asynchronous, about 1 ns settle.

Behaviour:
- Reset: one clock, CLK; RST is asynchronous, active-high.
- Reset values:
  - state = IDLE.
  - sram_csn = 1, sram_wen = 1, sram_addr = 0, sram_be = 0, sram_di = 0.
  - rsp0_valid = rsp1_valid = 0; rsp0_rdata = rsp1_rdata = 0.
  - last_grant = 1, so port 0 wins first.
- FSM states: IDLE, ACCESS.
- IDLE:
  - req*_ready is combinational; it is 1 only for the selected winner and only in IDLE.
  - Accept = valid & ready.
  - On accept: latch addr/we/be/wdata into the SRAM output registers, record owner, set last_grant = owner, go to ACCESS.
  - No valid: stay in IDLE.
- ACCESS (exactly one cycle):
  - sram_csn = 0; sram_wen = ~we; sram_addr/sram_be/sram_di come from the latched registers and are stable for the whole cycle.
  - The SRAM commits a write at the mid-cycle negedge.
  - At the closing posedge: if read, capture sram_dout into the owner's rsp_rdata. Set the owner's rsp_valid = 1 for one cycle. Return to IDLE.
- Writes also get an rsp_valid pulse as the write acknowledge; rsp_rdata is unchanged on writes.
- Outside ACCESS: sram_csn = 1 and sram_wen = 1; addr/be/di hold their last values.
- Throughput: one access per 2 cycles.
- Latency: accept at edge N; rsp_valid is high during cycle N+2, after edges N+1 and N+2.
- rsp pulse and the next accept may coincide, since IDLE follows ACCESS.
- Arbitration, both valid in IDLE:
  - Round-robin: grant the port != last_grant.
  - Single valid: grant it regardless of last_grant.
- Requester rules:
  - Requesters hold req fields stable while valid & !ready.
  - The arbiter never accepts a request from a port that has an outstanding access; at most one access is in flight.
- Reset mid-ACCESS:
  - csn and wen go to 1 immediately.
  - No rsp pulse.
  - A write whose negedge has already passed stays committed.
- Addresses are word indices; no range check; AWIDTH bits go straight to sram_addr.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins when both are valid, and last_grant is ignored. Port 1 may starve; this is intended for debug of the fetch path.
- Undefined (default): round-robin as above.

Test Plan:
- Port 0 read, SRAM word 0x010 preloaded 0xDEADBEEF, req0 valid at cycle 0 -> req0_ready=1 at cycle 0; sram_csn=0, sram_wen=1, sram_addr=0x010 during cycle 1; rsp0_valid=1 with rsp0_rdata=0xDEADBEEF at cycle 2.
- Port 1 write, addr 0x020, be=4'b0011, wdata 0x12345678 over 0xAABBCCDD, then a port 1 read of 0x020 -> write rsp1_valid pulse; read returns 0xAABB5678.
- req0 and req1 held valid continuously for 8 accesses -> grants alternate 0,1,0,1,...; each port gets 4 rsp pulses; first grant is port 0.
- Only req1 valid, three back-to-back reads -> accepted at cycles 0, 2 and 4; rsp1_valid at cycles 2, 4 and 6; rsp0_valid never asserts.
- RST asserted 3 ns after the ACCESS posedge of a write to 0x030 (before negedge) -> sram_csn=1 immediately; no rsp pulse; word 0x030 unchanged; state IDLE; outputs at reset values.
- Built with SRAM_ARB_FIXED_PRIO_EN, both ports held valid for 4 accesses -> all 4 grants to port 0; req1_ready stays 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter/sequencer for a single-port SRAM macro (one access per 2 cycles).
// Define SRAM_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module sram_port_arbiter #(
   parameter int AWIDTH = 12
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic [3:0]        req0_be,
   input  logic [AWIDTH-1:0] req0_addr,
   input  logic [31:0]       req0_wdata,
   output logic              rsp0_valid,
   output logic [31:0]       rsp0_rdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic [3:0]        req1_be,
   input  logic [AWIDTH-1:0] req1_addr,
   input  logic [31:0]       req1_wdata,
   output logic              rsp1_valid,
   output logic [31:0]       rsp1_rdata,
   output logic              sram_csn,
   output logic              sram_wen,
   output logic [AWIDTH-1:0] sram_addr,
   output logic [3:0]        sram_be,
   output logic [31:0]       sram_di,
   input  logic [31:0]       sram_dout
);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t state, state_nx;
   logic   last_grant;
   logic   owner;
   logic   we_q;
   logic   win0, win1;
   logic   acc0, acc1;

   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
      win0 = req0_valid;
      win1 = req1_valid & ~req0_valid;
`else
      // on contention the port that did not win last time goes next
      win0 = req0_valid & (~req1_valid | last_grant);
      win1 = req1_valid & (~req0_valid | ~last_grant);
`endif
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      sram_csn   = 1'b1;
      sram_wen   = 1'b1;
      unique case (state)
         IDLE: begin
            req0_ready = win0;
            req1_ready = win1;
            if (win0 | win1) state_nx = ACCESS;
         end
         ACCESS: begin
            sram_csn = 1'b0;
            sram_wen = ~we_q;
            state_nx = IDLE;
         end
      endcase
   end

   assign acc0 = req0_valid & req0_ready;
   assign acc1 = req1_valid & req1_ready;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         we_q       <= 1'b0;
         sram_addr  <= '0;
         sram_be    <= '0;
         sram_di    <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         if (acc0) begin
            owner      <= 1'b0;
            last_grant <= 1'b0;
            we_q       <= req0_we;
            sram_addr  <= req0_addr;
            sram_be    <= req0_be;
            sram_di    <= req0_wdata;
         end else if (acc1) begin
            owner      <= 1'b1;
            last_grant <= 1'b1;
            we_q       <= req1_we;
            sram_addr  <= req1_addr;
            sram_be    <= req1_be;
            sram_di    <= req1_wdata;
         end
         if (state == ACCESS) begin
            if (owner) begin
               rsp1_valid <= 1'b1;
               if (!we_q) rsp1_rdata <= sram_dout;
            end else begin
               rsp0_valid <= 1'b1;
               if (!we_q) rsp0_rdata <= sram_dout;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed steps plus a
// randomized phase checked against a transaction-level reference model.
module tb_sram_port_arbiter;

   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          req0_valid, req0_ready, req0_we;
   logic [3:0]    req0_be;
   logic [AW-1:0] req0_addr;
   logic [31:0]   req0_wdata;
   logic          rsp0_valid;
   logic [31:0]   rsp0_rdata;
   logic          req1_valid, req1_ready, req1_we;
   logic [3:0]    req1_be;
   logic [AW-1:0] req1_addr;
   logic [31:0]   req1_wdata;
   logic          rsp1_valid;
   logic [31:0]   rsp1_rdata;
   logic          sram_csn, sram_wen;
   logic [AW-1:0] sram_addr;
   logic [3:0]    sram_be;
   logic [31:0]   sram_di, sram_dout;

   logic [31:0] sram    [0:(1<<AW)-1];
   logic [31:0] ref_mem [0:15];

   int checks = 0;
   int errors = 0;

   sram_port_arbiter #(.AWIDTH(AW)) dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_be(req0_be), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_be(req1_be), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_be(sram_be), .sram_di(sram_di), .sram_dout(sram_dout)
   );

   always #5 CLK = ~CLK;

   // SRAM macro model: async read, byte-masked write on the falling edge
   assign sram_dout = sram[sram_addr];
   always @(negedge CLK) begin
      if (!sram_csn && !sram_wen) begin
         for (int b = 0; b < 4; b++)
            if (sram_be[b]) sram[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input bit v, input bit we,
                        input logic [3:0] be, input logic [AW-1:0] a,
                        input logic [31:0] wd);
      if (p == 0) begin
         req0_valid = v; req0_we = we; req0_be = be;
         req0_addr = a; req0_wdata = wd;
      end else begin
         req1_valid = v; req1_we = we; req1_be = be;
         req1_addr = a; req1_wdata = wd;
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      drive(0, 0, 0, 4'h0, '0, '0);
      drive(1, 0, 0, 4'h0, '0, '0);
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   // full transaction from IDLE; entered and left at posedge+1
   task automatic do_req(input int p, input bit we, input logic [3:0] be,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         output logic [31:0] rd);
      drive(p, 1, we, be, a, wd);
      #1;
      chk("ready", p ? req1_ready : req0_ready, 1);
      @(posedge CLK);
      #1;
      drive(p, 0, 0, 4'h0, '0, '0);
      chk("acc_csn", sram_csn, 0);
      chk("acc_wen", sram_wen, !we);
      chk("acc_addr", sram_addr, a);
      if (we) chk("acc_be", sram_be, be);
      if (we) chk("acc_di", sram_di, wd);
      @(posedge CLK);
      #1;
      chk("rsp_own", p ? rsp1_valid : rsp0_valid, 1);
      chk("rsp_oth", p ? rsp0_valid : rsp1_valid, 0);
      rd = p ? rsp1_rdata : rsp0_rdata;
   endtask

   function automatic int winner(bit v0, bit v1, int last);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      if (v0) return 0;
      if (v1) return 1;
      return -1;
`else
      if (v0 && v1) return (last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
`endif
   endfunction

   initial begin
      logic [31:0] rd;
      int cnt0, cnt1, e;
      bit pv [2];
      bit pwe [2];
      logic [3:0] pbe [2];
      logic [AW-1:0] pa [2];
      logic [31:0] pwd [2];
      bit m_idle, m_we;
      int m_last, m_p, w;
      logic [3:0] m_be;
      logic [AW-1:0] m_a;
      logic [31:0] m_wd;
      bit m_rsp [2];
      logic [31:0] m_rd [2];

      for (int i = 0; i < (1 << AW); i++) sram[i] = 32'h0;
      do_reset();
      chk("rst_csn", sram_csn, 1);
      chk("rst_wen", sram_wen, 1);
      chk("rst_addr", sram_addr, 0);
      chk("rst_be", sram_be, 0);
      chk("rst_di", sram_di, 0);
      chk("rst_rsp0", rsp0_valid, 0);
      chk("rst_rsp1", rsp1_valid, 0);
      chk("rst_rd0", rsp0_rdata, 0);
      chk("rst_rd1", rsp1_rdata, 0);

      sram[12'h010] = 32'hDEADBEEF;
      do_req(0, 0, 4'h0, 12'h010, 32'h0, rd);
      chk("p0_read", rd, 32'hDEADBEEF);

      sram[12'h020] = 32'hAABBCCDD;
      do_req(1, 1, 4'b0011, 12'h020, 32'h12345678, rd);
      chk("p1_wr_rd_kept", rd, 32'h0);
      do_req(1, 0, 4'h0, 12'h020, 32'h0, rd);
      chk("p1_be_merge", rd, 32'hAABB5678);

      sram[12'h040] = 32'h01010101;
      sram[12'h041] = 32'h02020202;
      sram[12'h042] = 32'h03030303;
      for (int i = 0; i < 3; i++) begin
         do_req(1, 0, 4'h0, AW'(12'h040 + i), 32'h0, rd);
         chk("p1_b2b", rd, 32'h01010101 * (i + 1));
      end
      chk("p0_quiet_rd", rsp0_rdata, 32'hDEADBEEF);

      sram[12'h030] = 32'h11111111;
      drive(0, 1, 1, 4'hF, 12'h030, 32'hCAFEF00D);
      @(posedge CLK);
      #3 RST = 1'b1;
      #1;
      chk("mid_csn", sram_csn, 1);
      chk("mid_wen", sram_wen, 1);
      chk("mid_addr", sram_addr, 0);
      drive(0, 0, 0, 4'h0, '0, '0);
      @(posedge CLK);
      #1;
      chk("mid_rsp0", rsp0_valid, 0);
      chk("mid_mem", sram[12'h030], 32'h11111111);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      chk("mid_idle_csn", sram_csn, 1);
      chk("mid_rd_rst", rsp0_rdata, 0);
      do_req(0, 0, 4'h0, 12'h030, 32'h0, rd);
      chk("mid_readback", rd, 32'h11111111);

      do_reset();
      cnt0 = 0;
      cnt1 = 0;
      drive(0, 1, 0, 4'h0, 12'h010, 32'h0);
      drive(1, 1, 0, 4'h0, 12'h020, 32'h0);
      for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
         e = 0;
`else
         e = i % 2;
`endif
         #1;
         chk("rr_ready0", req0_ready, e == 0);
         chk("rr_ready1", req1_ready, e == 1);
         @(posedge CLK);
         #1;
         @(posedge CLK);
         #1;
         chk("rr_rsp0", rsp0_valid, e == 0);
         chk("rr_rsp1", rsp1_valid, e == 1);
         cnt0 += int'(rsp0_valid);
         cnt1 += int'(rsp1_valid);
      end
      drive(0, 0, 0, 4'h0, '0, '0);
      drive(1, 0, 0, 4'h0, '0, '0);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      chk("rr_cnt0", cnt0, 8);
      chk("rr_cnt1", cnt1, 0);
`else
      chk("rr_cnt0", cnt0, 4);
      chk("rr_cnt1", cnt1, 4);
`endif

      do_reset();
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = $urandom;
         sram[i] = ref_mem[i];
      end
      pv = '{0, 0};
      m_idle = 1;
      m_last = 1;
      m_rsp = '{0, 0};
      m_rd = '{32'h0, 32'h0};
      m_p = 0; m_we = 0; m_be = 0; m_a = 0; m_wd = 0;
      for (int c = 0; c < 600; c++) begin
         chk("rnd_rsp0", rsp0_valid, m_rsp[0]);
         chk("rnd_rsp1", rsp1_valid, m_rsp[1]);
         chk("rnd_rd0", rsp0_rdata, m_rd[0]);
         chk("rnd_rd1", rsp1_rdata, m_rd[1]);
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && $urandom_range(0, 2) != 0) begin
               pv[p] = 1;
               pwe[p] = $urandom_range(0, 1) == 1;
               pbe[p] = 4'($urandom);
               pa[p] = AW'($urandom_range(0, 15));
               pwd[p] = $urandom;
            end
            drive(p, pv[p], pwe[p], pbe[p], pa[p], pwd[p]);
         end
         #1;
         w = m_idle ? winner(pv[0], pv[1], m_last) : -1;
         chk("rnd_ready0", req0_ready, w == 0);
         chk("rnd_ready1", req1_ready, w == 1);
         @(posedge CLK);
         m_rsp = '{0, 0};
         if (!m_idle) begin
            if (m_we) begin
               for (int b = 0; b < 4; b++)
                  if (m_be[b]) ref_mem[m_a[3:0]][8*b +: 8] = m_wd[8*b +: 8];
            end else begin
               m_rd[m_p] = ref_mem[m_a[3:0]];
            end
            m_rsp[m_p] = 1;
            m_idle = 1;
         end else if (w >= 0) begin
            m_p = w; m_we = pwe[w]; m_be = pbe[w];
            m_a = pa[w]; m_wd = pwd[w];
            pv[w] = 0;
            m_last = w;
            m_idle = 0;
         end
         #1;
      end
      for (int i = 0; i < 16; i++) chk("rnd_mem", sram[i], ref_mem[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
